// File: rtl/sram_bridge_if.sv
// sram_bridge_if -- bus bundle between a byte-wide CPU, the bridge and a
// 16-bit asynchronous SRAM.
//   CPU side : address, out (write data), we, in (read data), ce (stall)
//   SRAM side: sram_addr, sram_dq_i, sram_dq_o, sram_dq_oe, active-low strobes
// The bridge connects through the slave modport; the CPU/SRAM side
// (or a testbench) connects through the master modport.
interface sram_bridge_if;
  logic [19:0] address;
  logic [7:0]  out;
  logic        we;
  logic [7:0]  in;
  logic        ce;
  logic [18:0] sram_addr;
  logic [15:0] sram_dq_i;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_lb_n;
  logic        sram_ub_n;

  modport master (
    output address, out, we, sram_dq_i,
    input  in, ce, sram_addr, sram_dq_o, sram_dq_oe,
           sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
  );

  modport slave (
    input  address, out, we, sram_dq_i,
    output in, ce, sram_addr, sram_dq_o, sram_dq_oe,
           sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
  );
endinterface

// File: rtl/sram_bridge.sv
// sram_bridge -- connects an 8-bit CPU with a clock-enable stall input to a
// 16-bit asynchronous SRAM, with a one-word read cache in front of it.
// Ports:
//   clock : system clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   bus   : sram_bridge_if.slave (CPU request/response + SRAM pins)
// Parameter:
//   WAIT  : extra SRAM access cycles beyond one (0..15)
// A read hit completes with ce=1 in the same cycle. A miss stalls the CPU
// through one IDLE cycle plus WAIT+1 READ cycles, fills the cache, then hits.
// Writes go straight to SRAM (write-through on a cached word, no allocate)
// and finish with a single WACK cycle so a held write is never repeated.
module sram_bridge #(
  parameter int WAIT = 1
) (
  input  logic         clock,
  input  logic         reset,
  sram_bridge_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] WACK  = 2'd3;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  logic [1:0]  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        valid_reg;
  logic [18:0] tag_reg;
  logic [15:0] data_reg;
  logic [7:0]  in_reg;

  logic [18:0] word;
  logic        hit;
  logic        last_cycle;
  logic [15:0] merged;

  assign word       = bus.address[19:1];
  assign hit        = valid_reg && (tag_reg == word);
  assign last_cycle = (cnt_reg == 4'd0);

  // Cached word with the addressed byte replaced by the CPU write data.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign merged[gi*8 +: 8] = (bus.address[0] == 1'(gi)) ? bus.out
                                                           : data_reg[gi*8 +: 8];
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.we) begin
          state_next = WRITE;
          cnt_next   = WAIT_CNT;
        end else if (!hit) begin
          state_next = READ;
          cnt_next   = WAIT_CNT;
        end
      end
      READ: begin
        if (last_cycle) state_next = IDLE;
        else            cnt_next   = cnt_reg - 4'd1;
      end
      WRITE: begin
        if (last_cycle) state_next = WACK;
        else            cnt_next   = cnt_reg - 4'd1;
      end
      WACK:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      data_reg  <= '0;
      in_reg    <= 8'h00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && !bus.we && hit)
        in_reg <= bus.address[0] ? data_reg[15:8] : data_reg[7:0];
      if (state_reg == READ && last_cycle) begin
        valid_reg <= 1'b1;
        tag_reg   <= word;
        data_reg  <= bus.sram_dq_i;
        in_reg    <= bus.address[0] ? bus.sram_dq_i[15:8] : bus.sram_dq_i[7:0];
      end
      // Write-through keeps the cached copy coherent; misses do not allocate.
      if (state_reg == WRITE && last_cycle && hit)
        data_reg <= merged;
    end
  end

  // ce is the only combinational output; reset forces the CPU stalled.
  assign bus.ce = !reset && ((state_reg == IDLE && !bus.we && hit) ||
                             (state_reg == WACK));

  // SRAM strobes decode the registered state, so oe_n and we_n are exclusive.
  assign bus.sram_oe_n  = (state_reg != READ);
  assign bus.sram_we_n  = (state_reg != WRITE);
  assign bus.sram_lb_n  = (state_reg == READ)  ? 1'b0 :
                          (state_reg == WRITE) ? bus.address[0] : 1'b1;
  assign bus.sram_ub_n  = (state_reg == READ)  ? 1'b0 :
                          (state_reg == WRITE) ? ~bus.address[0] : 1'b1;
  assign bus.sram_dq_oe = (state_reg == WRITE);
  assign bus.sram_dq_o  = (state_reg == WRITE) ? {bus.out, bus.out} : 16'h0000;
  assign bus.sram_addr  = word;
  assign bus.in         = in_reg;

endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge -- directed test of sram_bridge with WAIT=1 (dut1) and
// WAIT=0 (dut0). A CPU model holds each request until it sees ce=1 at an edge.
module tb_sram_bridge;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset1, reset0;

  sram_bridge_if if1();
  sram_bridge_if if0();

  sram_bridge #(.WAIT(1)) dut1 (.clock(clock), .reset(reset1), .bus(if1.slave));
  sram_bridge #(.WAIT(0)) dut0 (.clock(clock), .reset(reset0), .bus(if0.slave));

  int tests = 0;
  int fails = 0;

  // results of the last cpu_access
  int          stall, oe_cnt, we_cnt, both_low;
  logic [7:0]  rd;
  logic        w_ub, w_lb, w_oe;
  logic [15:0] w_dq;

  // Drive one CPU request, hold it until ce=1 is seen at an edge.
  // Entered and left #1 after a rising edge.
  task automatic cpu_access(input bit sel, input logic [19:0] a,
                            input logic w, input logic [7:0] d);
    logic ce_s, oe_s, we_s;
    bit   done;
    stall = 0; oe_cnt = 0; we_cnt = 0; both_low = 0; done = 0;
    w_ub = 1'b1; w_lb = 1'b1; w_oe = 1'b0; w_dq = 16'h0;
    if (sel) begin if1.address = a; if1.we = w; if1.out = d; end
    else     begin if0.address = a; if0.we = w; if0.out = d; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      ce_s = sel ? if1.ce : if0.ce;
      oe_s = sel ? if1.sram_oe_n : if0.sram_oe_n;
      we_s = sel ? if1.sram_we_n : if0.sram_we_n;
      if (!oe_s) oe_cnt++;
      if (!we_s) begin
        we_cnt++;
        w_ub = sel ? if1.sram_ub_n  : if0.sram_ub_n;
        w_lb = sel ? if1.sram_lb_n  : if0.sram_lb_n;
        w_oe = sel ? if1.sram_dq_oe : if0.sram_dq_oe;
        w_dq = sel ? if1.sram_dq_o  : if0.sram_dq_o;
      end
      if (!oe_s && !we_s) both_low++;
      @(posedge clock); #1;
      if (ce_s) begin done = 1; break; end
      stall++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL access_timeout: addr %h got no ce=1 within 40 cycles expected completion", a);
    end
    rd = sel ? if1.in : if0.in;
    $display("[TB] dut%0d %s addr=%h data=%h stall=%0d oe=%0d we=%0d in=%h",
             sel, w ? "WR" : "RD", a, d, stall, oe_cnt, we_cnt, rd);
  endtask

  task automatic test_reset();
    reset1 = 1'b1; reset0 = 1'b1;
    if1.address = 20'h00000; if1.we = 1'b0; if1.out = 8'h00; if1.sram_dq_i = 16'h0;
    if0.address = 20'h00000; if0.we = 1'b0; if0.out = 8'h00; if0.sram_dq_i = 16'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests++; if (if1.ce !== 1'b0) begin fails++; $display("FAIL rst_ce: got %b expected 0", if1.ce); end
    tests++; if (if1.sram_oe_n !== 1'b1) begin fails++; $display("FAIL rst_oe_n: got %b expected 1", if1.sram_oe_n); end
    tests++; if (if1.sram_we_n !== 1'b1) begin fails++; $display("FAIL rst_we_n: got %b expected 1", if1.sram_we_n); end
    tests++; if (if1.sram_lb_n !== 1'b1) begin fails++; $display("FAIL rst_lb_n: got %b expected 1", if1.sram_lb_n); end
    tests++; if (if1.sram_ub_n !== 1'b1) begin fails++; $display("FAIL rst_ub_n: got %b expected 1", if1.sram_ub_n); end
    tests++; if (if1.sram_dq_oe !== 1'b0) begin fails++; $display("FAIL rst_dq_oe: got %b expected 0", if1.sram_dq_oe); end
    tests++; if (if1.sram_dq_o !== 16'h0) begin fails++; $display("FAIL rst_dq_o: got %h expected 0000", if1.sram_dq_o); end
    tests++; if (if1.in !== 8'h00) begin fails++; $display("FAIL rst_in: got %h expected 00", if1.in); end
    $display("[TB] reset checked");
    @(posedge clock); #1;
    reset1 = 1'b0;
  endtask

  task automatic test_read_miss();
    if1.sram_dq_i = 16'hBEEF;
    cpu_access(1'b1, 20'h00010, 1'b0, 8'h00);
    tests++; if (stall !== 3) begin fails++; $display("FAIL miss_stall: got %0d expected 3", stall); end
    tests++; if (oe_cnt !== 2) begin fails++; $display("FAIL miss_oe_cycles: got %0d expected 2", oe_cnt); end
    tests++; if (rd !== 8'hEF) begin fails++; $display("FAIL miss_data: got %h expected ef", rd); end
  endtask

  task automatic test_read_hit();
    if1.sram_dq_i = 16'h0000;  // a hit must not look at the SRAM
    cpu_access(1'b1, 20'h00011, 1'b0, 8'h00);
    tests++; if (stall !== 0) begin fails++; $display("FAIL hit_stall: got %0d expected 0", stall); end
    tests++; if (oe_cnt !== 0) begin fails++; $display("FAIL hit_oe_cycles: got %0d expected 0", oe_cnt); end
    tests++; if (rd !== 8'hBE) begin fails++; $display("FAIL hit_data: got %h expected be", rd); end
  endtask

  task automatic test_write_through();
    cpu_access(1'b1, 20'h00011, 1'b1, 8'h55);
    tests++; if (stall !== 3) begin fails++; $display("FAIL wr_stall: got %0d expected 3", stall); end
    tests++; if (we_cnt !== 2) begin fails++; $display("FAIL wr_we_cycles: got %0d expected 2", we_cnt); end
    tests++; if (oe_cnt !== 0) begin fails++; $display("FAIL wr_oe_cycles: got %0d expected 0", oe_cnt); end
    tests++; if (both_low !== 0) begin fails++; $display("FAIL wr_oe_we_overlap: got %0d expected 0", both_low); end
    tests++; if (w_ub !== 1'b0 || w_lb !== 1'b1) begin fails++; $display("FAIL wr_lanes: got ub=%b lb=%b expected ub=0 lb=1", w_ub, w_lb); end
    tests++; if (w_dq !== 16'h5555) begin fails++; $display("FAIL wr_dq_o: got %h expected 5555", w_dq); end
    tests++; if (w_oe !== 1'b1) begin fails++; $display("FAIL wr_dq_oe: got %b expected 1", w_oe); end
    tests++; if (rd !== 8'hBE) begin fails++; $display("FAIL wr_in_held: got %h expected be", rd); end
    cpu_access(1'b1, 20'h00011, 1'b0, 8'h00);
    tests++; if (stall !== 0 || rd !== 8'h55) begin fails++; $display("FAIL wr_hit_hi: got stall=%0d in=%h expected stall=0 in=55", stall, rd); end
    cpu_access(1'b1, 20'h00010, 1'b0, 8'h00);
    tests++; if (stall !== 0 || rd !== 8'hEF) begin fails++; $display("FAIL wr_hit_lo: got stall=%0d in=%h expected stall=0 in=ef", stall, rd); end
  endtask

  task automatic test_no_allocate();
    cpu_access(1'b1, 20'h00020, 1'b1, 8'hAA);
    tests++; if (stall !== 3 || w_lb !== 1'b0 || w_ub !== 1'b1) begin fails++; $display("FAIL na_write: got stall=%0d lb=%b ub=%b expected stall=3 lb=0 ub=1", stall, w_lb, w_ub); end
    cpu_access(1'b1, 20'h00010, 1'b0, 8'h00);
    tests++; if (stall !== 0 || rd !== 8'hEF) begin fails++; $display("FAIL na_old_hit: got stall=%0d in=%h expected stall=0 in=ef", stall, rd); end
    if1.sram_dq_i = 16'h1234;
    cpu_access(1'b1, 20'h00020, 1'b0, 8'h00);
    tests++; if (stall !== 3 || oe_cnt !== 2) begin fails++; $display("FAIL na_miss: got stall=%0d oe=%0d expected stall=3 oe=2", stall, oe_cnt); end
    tests++; if (rd !== 8'h34) begin fails++; $display("FAIL na_miss_data: got %h expected 34", rd); end
  endtask

  task automatic test_wait0_and_abort();
    if0.sram_dq_i = 16'hCAFE;
    reset0 = 1'b0;
    cpu_access(1'b0, 20'h00101, 1'b0, 8'h00);
    tests++; if (stall !== 2 || oe_cnt !== 1) begin fails++; $display("FAIL w0_miss: got stall=%0d oe=%0d expected stall=2 oe=1", stall, oe_cnt); end
    tests++; if (rd !== 8'hCA) begin fails++; $display("FAIL w0_data: got %h expected ca", rd); end
    // start a miss, then reset while it is in READ
    if0.address = 20'h00200; if0.we = 1'b0;
    @(negedge clock);
    tests++; if (if0.ce !== 1'b0) begin fails++; $display("FAIL ab_idle_ce: got %b expected 0", if0.ce); end
    @(posedge clock); #1;
    reset0 = 1'b1;
    @(negedge clock);
    tests++; if (if0.sram_oe_n !== 1'b0) begin fails++; $display("FAIL ab_in_read: got oe_n=%b expected 0", if0.sram_oe_n); end
    @(posedge clock); #1;
    @(negedge clock);
    tests++; if (if0.sram_oe_n !== 1'b1 || if0.sram_lb_n !== 1'b1 || if0.sram_ub_n !== 1'b1) begin fails++; $display("FAIL ab_strobes: got oe_n=%b lb_n=%b ub_n=%b expected 1 1 1", if0.sram_oe_n, if0.sram_lb_n, if0.sram_ub_n); end
    tests++; if (if0.in !== 8'h00 || if0.ce !== 1'b0) begin fails++; $display("FAIL ab_in_ce: got in=%h ce=%b expected in=00 ce=0", if0.in, if0.ce); end
    $display("[TB] dut0 reset during READ");
    @(posedge clock); #1;
    reset0 = 1'b0;
    cpu_access(1'b0, 20'h00101, 1'b0, 8'h00);
    tests++; if (stall !== 2 || oe_cnt !== 1) begin fails++; $display("FAIL ab_cache_invalid: got stall=%0d oe=%0d expected stall=2 oe=1", stall, oe_cnt); end
    tests++; if (rd !== 8'hCA) begin fails++; $display("FAIL ab_refill: got %h expected ca", rd); end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_through();
    test_no_allocate();
    test_wait0_and_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_bridge.md
SRAM_BRIDGE -- requirements
Module: sram_bridge

Interface
REQ-001 Parameter: WAIT, default 1, number of extra SRAM access cycles beyond one (0..15).
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 address  input  20  CPU byte address, held stable by the CPU while ce=0.
REQ-005 out  input  8  CPU write data, valid with we=1.
REQ-006 we  input  1  CPU write request; 0 means the cycle is a read of address.
REQ-007 in  output  8  registered read data to the CPU.
REQ-008 ce  output  1  CPU clock enable; 0 stalls the CPU.
REQ-009 sram_addr  output  19  SRAM word address, equal to address[19:1].
REQ-010 sram_dq_i  input  16  SRAM read data.
REQ-011 sram_dq_o  output  16  SRAM write data.
REQ-012 sram_dq_oe  output  1  1 while the bridge drives the SRAM data bus.
REQ-013 sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  output  1 each  active-low SRAM strobes.

Function
REQ-014 SHALL hold a one-word read cache: valid bit, 19-bit tag, 16-bit data.
REQ-015 SHALL use states IDLE, READ, WRITE, WACK; reset enters IDLE.
REQ-016 IDLE, we=0, valid and tag==address[19:1] (hit): ce=1; in <= address[0] ? data[15:8] : data[7:0] at the edge; no SRAM strobe.
REQ-017 IDLE, we=0, miss: ce=0 combinationally; next state READ; wait counter loaded with WAIT.
REQ-018 READ: ce=0, sram_oe_n=0, sram_lb_n=sram_ub_n=0, sram_dq_oe=0; counter decrements each cycle.
REQ-019 READ with counter==0: at that edge, cache <= {1, address[19:1], sram_dq_i}; in <= selected byte of sram_dq_i; next state IDLE, which then hits.
REQ-020 Read-miss cost: WAIT+2 cycles with ce=0, then a hit cycle with ce=1.
REQ-021 IDLE, we=1: ce=0; next state WRITE; counter loaded with WAIT.
REQ-022 WRITE: ce=0, sram_we_n=0, sram_dq_oe=1, sram_dq_o={out,out}; sram_lb_n=address[0], sram_ub_n=~address[0].
REQ-023 WRITE with counter==0: if cache valid and tag matches, update the addressed byte of cached data with out (write-through); next state WACK.
REQ-024 WACK: ce=1 for exactly one cycle, no SRAM strobe, in unchanged; next state IDLE, so a held write is never repeated.
REQ-025 Strobes SHALL be registered-state decodes only; oe_n and we_n never low in the same cycle.
REQ-026 sram_addr SHALL equal address[19:1] in every state.
REQ-027 WAIT=0 SHALL give one-cycle READ and WRITE states.
REQ-028 A write to a word not in the cache SHALL leave the cache unchanged (no write-allocate).
REQ-029 in SHALL change only on REQ-016/REQ-019 edges and reset.

Reset
REQ-030 While reset=1: state IDLE, cache valid=0, in=8'h00, ce=0, sram_oe_n=sram_we_n=sram_lb_n=sram_ub_n=1, sram_dq_oe=0, sram_dq_o=0.
REQ-031 Reset asserted during READ or WRITE SHALL abort the access at the next edge with no cache update; the first post-reset read misses.

Verification
REQ-032 Reset then read 20'h00010, sram_dq_i=16'hBEEF, WAIT=1 -> ce=0 for 3 cycles, oe_n low 2 cycles, then ce=1 with in=8'hEF.
REQ-033 Next read 20'h00011 -> hit, ce stays 1, no oe_n pulse, in=8'hBE one edge later.
REQ-034 Write 20'h00011, out=8'h55, WAIT=1 -> we_n low 2 cycles, ub_n=0, lb_n=1, sram_dq_o=16'h5555, one WACK cycle with ce=1; then read 20'h00011 -> hit, in=8'h55.
REQ-035 Write 20'h00020 (uncached) then read 20'h00010 -> hit on old word; read 20'h00020 -> miss with SRAM access.
REQ-036 WAIT=0 read miss -> ce=0 for exactly 2 cycles; reset asserted mid-READ -> strobes high next cycle, cache invalid.
